// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dffq_bank_unload.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__dffq_bank_unload
//
// Read-back unloader for a bank of dffq storage flops. A single capture request
// snapshots the parallel Q bus. The captured word is then sent LSB-first over
// a valid/ready serial link to the characterization/readout logic.
//
// Parameters
//   WIDTH   number of Q bits in the bank (1..64)
//
// Ports
//   CLK     rising-edge clock
//   RN      asynchronous active-low reset (deassertion synchronized upstream)
//   CAP     capture request, only honoured in IDLE
//   PQ      parallel Q bus from the flop bank, sampled on the capture edge
//   SO      serial data bit, LSB first
//   SO_VLD  SO holds a valid bit
//   SO_RDY  downstream accepts SO this cycle
//   BUSY    high from the capture edge until the last bit transfers
//   DONE    one-cycle pulse after the last bit transfers
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__dffq_bank_unload #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             CAP,
   input  logic [WIDTH-1:0] PQ,
   output logic             SO,
   output logic             SO_VLD,
   input  logic             SO_RDY,
   output logic             BUSY,
   output logic             DONE
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   sreg_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               so_q;
   logic               vld_q;
   logic               busy_q;
   logic               done_q;

   // Shift register after dropping the bit currently on SO. Its LSB is the
   // next bit to present; for WIDTH=1 it is simply zero and never used.
   logic [WIDTH-1:0]   sreg_d;
   logic               xfer_d;

   assign sreg_d = sreg_q >> 1;
   assign xfer_d = vld_q & SO_RDY;

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state_q <= ST_IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         so_q    <= 1'b0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (CAP) begin
                  // SO is loaded straight from the bus so the first bit is
                  // valid one cycle after the capture edge.
                  sreg_q  <= PQ;
                  cnt_q   <= CNT_W'(WIDTH - 1);
                  so_q    <= PQ[0];
                  vld_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= ST_SHIFT;
               end
            end

            ST_SHIFT: begin
               // cnt_q counts the bits still to follow the one on SO.
               if (xfer_d) begin
                  if (cnt_q != '0) begin
                     sreg_q <= sreg_d;
                     cnt_q  <= cnt_q - CNT_W'(1);
                     so_q   <= sreg_d[0];
                  end else begin
                     so_q    <= 1'b0;
                     vld_q   <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end
            end

            ST_DONE: begin
               // CAP is deliberately ignored here: this cycle is the
               // mandatory gap between back-to-back frames.
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end

            default: begin
               so_q    <= 1'b0;
               vld_q   <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign SO     = so_q;
   assign SO_VLD = vld_q;
   assign BUSY   = busy_q;
   assign DONE   = done_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__dffq_bank_unload.sv
// -----------------------------------------------------------------------------
// Bench for gf180mcu_fd_sc_mcu7t5v0__dffq_bank_unload. Two instances share the
// clock and reset: unit 0 with WIDTH=8, unit 1 with WIDTH=1. A frame-level
// reference model (captured word, bit index, bits remaining, done flag) gives
// the expected value of every output at every cycle.
// -----------------------------------------------------------------------------
module tb_gf180mcu_fd_sc_mcu7t5v0__dffq_bank_unload;

   logic       clk = 1'b0;
   logic       rn  = 1'b0;

   logic       cap8 = 1'b0, rdy8 = 1'b0;
   logic [7:0] pq8  = '0;
   logic       so8, vld8, busy8, done8;

   logic       cap1 = 1'b0, rdy1 = 1'b0;
   logic [0:0] pq1  = '0;
   logic       so1, vld1, busy1, done1;

   int n_checks = 0;
   int n_errors = 0;

   // reference model, indexed by unit
   logic [63:0] m_word [2];
   int          m_left [2];
   int          m_idx  [2];
   bit          m_done [2];
   int          exp_done_cnt [2];
   int          act_done_cnt [2];

   always #5 clk = ~clk;

   gf180mcu_fd_sc_mcu7t5v0__dffq_bank_unload #(.WIDTH(8)) dut8 (
      .CLK(clk), .RN(rn), .CAP(cap8), .PQ(pq8), .SO(so8), .SO_VLD(vld8),
      .SO_RDY(rdy8), .BUSY(busy8), .DONE(done8)
   );

   gf180mcu_fd_sc_mcu7t5v0__dffq_bank_unload #(.WIDTH(1)) dut1 (
      .CLK(clk), .RN(rn), .CAP(cap1), .PQ(pq1), .SO(so1), .SO_VLD(vld1),
      .SO_RDY(rdy1), .BUSY(busy1), .DONE(done1)
   );

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         m_word[u] = '0;
         m_left[u] = 0;
         m_idx[u]  = 0;
         m_done[u] = 1'b0;
      end
   endtask

   // One clock edge of the behavioural model for one unit.
   task automatic model_edge(input int u, input bit cap, input logic [63:0] pq,
                             input bit rdy, input int w);
      if (!rn) begin
         m_word[u] = '0; m_left[u] = 0; m_idx[u] = 0; m_done[u] = 1'b0;
      end else if (m_done[u]) begin
         m_done[u] = 1'b0;                 // gap cycle, request ignored
      end else if (m_left[u] == 0) begin
         if (cap) begin
            m_word[u] = pq;
            m_left[u] = w;
            m_idx[u]  = 0;
         end
      end else if (rdy) begin
         m_idx[u]++;
         m_left[u]--;
         if (m_left[u] == 0) begin
            m_done[u] = 1'b1;
            exp_done_cnt[u]++;
         end
      end
   endtask

   function automatic logic exp_so(input int u);
      logic [63:0] w;
      w = m_word[u] >> m_idx[u];
      return (m_left[u] != 0) ? w[0] : 1'b0;
   endfunction

   task automatic check_outputs();
      check_val("so8",   64'(so8),   64'(exp_so(0)));
      check_val("vld8",  64'(vld8),  64'(m_left[0] != 0));
      check_val("busy8", 64'(busy8), 64'(m_left[0] != 0));
      check_val("done8", 64'(done8), 64'(m_done[0]));
      check_val("so1",   64'(so1),   64'(exp_so(1)));
      check_val("vld1",  64'(vld1),  64'(m_left[1] != 0));
      check_val("busy1", 64'(busy1), 64'(m_left[1] != 0));
      check_val("done1", 64'(done1), 64'(m_done[1]));
      if (done8) begin
         act_done_cnt[0]++;
         $display("t=%0t unit0 frame %0d complete", $time, act_done_cnt[0]);
      end
      if (done1) begin
         act_done_cnt[1]++;
         $display("t=%0t unit1 frame %0d complete", $time, act_done_cnt[1]);
      end
   endtask

   // Inputs are driven at the negedge; the model advances on the posedge
   // using the same values the DUT samples; outputs are checked at the
   // following negedge.
   task automatic step();
      @(posedge clk);
      model_edge(0, cap8, 64'(pq8), rdy8, 8);
      model_edge(1, cap1, 64'(pq1), rdy1, 1);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic drive8(input bit cap, input logic [7:0] pq, input bit rdy);
      cap8 = cap; pq8 = pq; rdy8 = rdy;
      step();
   endtask

   task automatic check_done_delta(input string tag, input int a0, input int e0);
      check_val(tag, 64'(act_done_cnt[0] - a0), 64'(exp_done_cnt[0] - e0));
   endtask

   initial begin
      int a0, e0;
      int vpat [3];
      int dpat [3];
      vpat = '{1, 0, 0};
      dpat = '{0, 1, 0};
      for (int u = 0; u < 2; u++) begin
         exp_done_cnt[u] = 0;
         act_done_cnt[u] = 0;
      end
      model_reset();

      // 1: reset held with random activity on the inputs
      for (int i = 0; i < 6; i++) begin
         cap8 = 1'($urandom); pq8 = 8'($urandom); rdy8 = 1'($urandom);
         cap1 = 1'($urandom); pq1 = 1'($urandom); rdy1 = 1'($urandom);
         step();
      end
      #2;
      check_val("rst_mid_so8",   64'(so8),   64'(0));
      check_val("rst_mid_vld8",  64'(vld8),  64'(0));
      check_val("rst_mid_busy8", 64'(busy8), 64'(0));
      check_val("rst_mid_done8", 64'(done8), 64'(0));
      @(negedge clk);
      rn = 1'b1;
      cap1 = 1'b0; rdy1 = 1'b1;

      // 2: A5, no backpressure
      a0 = act_done_cnt[0]; e0 = exp_done_cnt[0];
      drive8(1'b1, 8'hA5, 1'b1);
      for (int i = 0; i < 10; i++) drive8(1'b0, 8'h00, 1'b1);
      check_done_delta("t2_done_cnt", a0, e0);
      check_val("t2_one_frame", 64'(exp_done_cnt[0] - e0), 64'(1));

      // 3: A5 with a 3-cycle stall while the 2nd bit is on SO
      a0 = act_done_cnt[0]; e0 = exp_done_cnt[0];
      drive8(1'b1, 8'hA5, 1'b1);          // capture, bit0 presented
      drive8(1'b0, 8'h00, 1'b1);          // bit0 taken, bit1 presented
      for (int i = 0; i < 3; i++) begin
         drive8(1'b0, 8'h00, 1'b0);
         check_val("t3_stall_so",  64'(so8),  64'(0));
         check_val("t3_stall_vld", 64'(vld8), 64'(1));
      end
      for (int i = 0; i < 10; i++) drive8(1'b0, 8'h00, 1'b1);
      check_done_delta("t3_done_cnt", a0, e0);

      // 4: PQ change and CAP pulse mid-frame are ignored
      a0 = act_done_cnt[0]; e0 = exp_done_cnt[0];
      drive8(1'b1, 8'hA5, 1'b1);
      drive8(1'b0, 8'hFF, 1'b1);
      drive8(1'b1, 8'hFF, 1'b1);
      for (int i = 0; i < 12; i++) drive8(1'b0, 8'hFF, 1'b1);
      check_done_delta("t4_done_cnt", a0, e0);
      check_val("t4_one_frame", 64'(act_done_cnt[0] - a0), 64'(1));

      // 5: asynchronous reset after 4 bits, then a fresh 3C frame
      a0 = act_done_cnt[0]; e0 = exp_done_cnt[0];
      drive8(1'b1, 8'hA5, 1'b1);
      for (int i = 0; i < 4; i++) drive8(1'b0, 8'h00, 1'b1);
      #2 rn = 1'b0;
      #1;
      model_reset();
      check_val("t5_async_vld8",  64'(vld8),  64'(0));
      check_val("t5_async_busy8", 64'(busy8), 64'(0));
      check_val("t5_async_so8",   64'(so8),   64'(0));
      drive8(1'b0, 8'h00, 1'b1);
      rn = 1'b1;
      drive8(1'b1, 8'h3C, 1'b1);
      for (int i = 0; i < 10; i++) drive8(1'b0, 8'h00, 1'b1);
      check_done_delta("t5_done_cnt", a0, e0);
      check_val("t5_one_frame", 64'(act_done_cnt[0] - a0), 64'(1));

      // 6: WIDTH=1 with CAP held high repeats with period 3
      cap8 = 1'b0;
      cap1 = 1'b1; pq1 = 1'b1; rdy1 = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step();
         check_val("t6_vld1",  64'(vld1),  64'(vpat[i % 3]));
         check_val("t6_done1", 64'(done1), 64'(dpat[i % 3]));
         if (vpat[i % 3] == 1) check_val("t6_so1", 64'(so1), 64'(1));
      end
      cap1 = 1'b0;
      step(); step();

      // random traffic on both units, with occasional resets
      for (int i = 0; i < 800; i++) begin
         cap8 = ($urandom_range(0, 3) == 0);
         pq8  = 8'($urandom);
         rdy8 = 1'($urandom);
         cap1 = ($urandom_range(0, 2) == 0);
         pq1  = 1'($urandom);
         rdy1 = 1'($urandom);
         rn   = ($urandom_range(0, 79) != 0);
         step();
      end
      rn = 1'b1;
      check_val("rand_done_cnt0", 64'(act_done_cnt[0]), 64'(exp_done_cnt[0]));
      check_val("rand_done_cnt1", 64'(act_done_cnt[1]), 64'(exp_done_cnt[1]));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
